// File: rtl/text_console_writer_if.sv
// -----------------------------------------------------------------------------
// text_console_writer_if
//
// Bundles the byte-stream handshake and the text RAM write port of the
// console writer. Signal names carry the direction as seen from the writer.
//
//   chr_i        byte from the source (ASCII or control code)
//   chr_valid_i  chr_i holds a byte
//   chr_ready_o  writer accepts a byte at the next rising edge
//   ram_addr_o   text RAM write address
//   ram_data_o   7-bit character ordinal to write
//   ram_we_o     text RAM write enable, one cycle per write
//
// Modports:
//   master  byte source / RAM side (drives chr_*, observes ready and RAM port)
//   slave   the console writer itself
// -----------------------------------------------------------------------------
interface text_console_writer_if #(
  parameter int ADDR_W = 13
);
  logic [7:0]        chr_i;
  logic              chr_valid_i;
  logic              chr_ready_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [6:0]        ram_data_o;
  logic              ram_we_o;

  modport master (
    output chr_i,
    output chr_valid_i,
    input  chr_ready_o,
    input  ram_addr_o,
    input  ram_data_o,
    input  ram_we_o
  );

  modport slave (
    input  chr_i,
    input  chr_valid_i,
    output chr_ready_o,
    output ram_addr_o,
    output ram_data_o,
    output ram_we_o
  );
endinterface

// File: rtl/text_console_writer.sv
// -----------------------------------------------------------------------------
// text_console_writer
//
// Writer side of the 8x8-cell text display. Consumes a byte stream of ASCII
// characters and control codes (CR, LF, BS, FF), writes 7-bit character
// ordinals into the screen text RAM, tracks the cursor and scrolls the screen
// through a top-line offset that the display-side address generator adds to
// its own line index.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         asynchronous, active-high reset
//   bus           byte handshake + text RAM write port (slave modport)
//   cursor_col_o  cursor column, 0..COLS-1
//   cursor_lin_o  cursor logical line, 0..ROWS-1
//   top_lin_o     physical RAM line currently shown at the top of the screen
//
// Parameters:
//   COLS    characters per line
//   ROWS    lines per screen
//   ADDR_W  text RAM address width, COLS*ROWS <= 2**ADDR_W
//
// All outputs are registered. After reset the whole RAM is cleared to spaces
// before the first byte is accepted.
// -----------------------------------------------------------------------------
module text_console_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int ADDR_W = 13
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  text_console_writer_if.slave bus,
  output logic [6:0]           cursor_col_o,
  output logic [5:0]           cursor_lin_o,
  output logic [5:0]           top_lin_o
);

  localparam int                TOTAL     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(TOTAL - COLS);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]        LAST_LIN  = 6'(ROWS - 1);
  localparam logic [6:0]        SPACE     = 7'h20;

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,     // waiting for a byte, the only state with ready high
    S_WRITE,    // one character write cycle
    S_NEWLINE,  // cursor / scroll update
    S_CLEAR,    // blank the line that just scrolled in at the bottom
    S_CLS       // blank the whole screen
  } state_e;

  state_e            state_q;
  logic [6:0]        col_q;
  logic [5:0]        lin_q;
  logic [5:0]        top_q;
  // Line bases are kept pre-multiplied by COLS so no multiplier is needed:
  // line_base_q is the RAM base of the cursor's physical line, top_base_q
  // the base of the physical line shown at the top of the screen.
  logic [ADDR_W-1:0] line_base_q;
  logic [ADDR_W-1:0] top_base_q;
  logic [6:0]        clr_col_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [6:0]        ram_data_q;
  logic              ram_we_q;
  logic              ready_q;

  logic [ADDR_W-1:0] cur_addr_d;
  logic [ADDR_W-1:0] line_base_next_d;
  logic [ADDR_W-1:0] top_base_next_d;
  logic [5:0]        top_next_d;
  logic              printable_d;
  logic              accept_d;

  assign cur_addr_d  = line_base_q + ADDR_W'(col_q);
  assign printable_d = (bus.chr_i >= 8'h20) && (bus.chr_i <= 8'h7E);
  assign accept_d    = ready_q && bus.chr_valid_i;

  // A base never exceeds LAST_BASE, so wrapping only needs an equality test
  // and the sum can never overflow ADDR_W bits.
  assign line_base_next_d = (line_base_q == LAST_BASE) ? '0 : line_base_q + COLS_A;
  assign top_base_next_d  = (top_base_q  == LAST_BASE) ? '0 : top_base_q  + COLS_A;
  assign top_next_d       = (top_q == LAST_LIN) ? '0 : top_q + 6'd1;

  // NOTE: every register in this block uses non-blocking assignment so all
  // next-state values are computed from the same pre-edge snapshot; blocking
  // assignment here would let later statements see half-updated state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_CLS;
      col_q       <= '0;
      lin_q       <= '0;
      top_q       <= '0;
      line_base_q <= '0;
      top_base_q  <= '0;
      clr_col_q   <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_we_q    <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            if (printable_d) begin
              ram_we_q   <= 1'b1;
              ram_data_q <= bus.chr_i[6:0];
              ram_addr_q <= cur_addr_d;
              ready_q    <= 1'b0;
              state_q    <= S_WRITE;
            end else begin
              case (bus.chr_i)
                CHR_CR: col_q <= '0;
                CHR_BS: if (col_q != '0) col_q <= col_q - 7'd1;
                CHR_LF: begin
                  ready_q <= 1'b0;
                  state_q <= S_NEWLINE;
                end
                CHR_FF: begin
                  col_q       <= '0;
                  lin_q       <= '0;
                  top_q       <= '0;
                  line_base_q <= '0;
                  top_base_q  <= '0;
                  // First clear-screen write is issued right away.
                  ram_we_q    <= 1'b1;
                  ram_addr_q  <= '0;
                  ram_data_q  <= SPACE;
                  ready_q     <= 1'b0;
                  state_q     <= S_CLS;
                end
                default: ;  // unsupported byte: consumed, no effect
              endcase
            end
          end
        end

        S_WRITE: begin
          ram_we_q <= 1'b0;
          if (col_q == LAST_COL) begin
            state_q <= S_NEWLINE;  // auto-wrap
          end else begin
            col_q   <= col_q + 7'd1;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        S_NEWLINE: begin
          col_q <= '0;
          if (lin_q != LAST_LIN) begin
            lin_q       <= lin_q + 6'd1;
            line_base_q <= line_base_next_d;
            ready_q     <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            // Scrolling: the old top line becomes the new bottom line, so it
            // is both the cursor's new line and the line to blank.
            top_q       <= top_next_d;
            top_base_q  <= top_base_next_d;
            line_base_q <= top_base_q;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= top_base_q;
            ram_data_q  <= SPACE;
            clr_col_q   <= '0;
            state_q     <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (clr_col_q == LAST_COL) begin
            ram_we_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            clr_col_q  <= clr_col_q + 7'd1;
            ram_addr_q <= ram_addr_q + ADDR_ONE;
          end
        end

        S_CLS: begin
          if (!ram_we_q) begin
            // Entered from reset with no write yet on the port: start at 0.
            ram_we_q   <= 1'b1;
            ram_addr_q <= '0;
            ram_data_q <= SPACE;
          end else if (ram_addr_q == LAST_ADDR) begin
            ram_we_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            ram_addr_q <= ram_addr_q + ADDR_ONE;
          end
        end

        default: begin
          ram_we_q <= 1'b0;
          ready_q  <= 1'b0;
          state_q  <= S_CLS;
        end
      endcase
    end
  end

  assign bus.chr_ready_o = ready_q;
  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_data_o  = ram_data_q;
  assign bus.ram_we_o    = ram_we_q;
  assign cursor_col_o    = col_q;
  assign cursor_lin_o    = lin_q;
  assign top_lin_o       = top_q;

endmodule

// File: tb/tb_text_console_writer.sv
// -----------------------------------------------------------------------------
// tb_text_console_writer
//
// Drives bytes into text_console_writer and compares every cycle of its
// outputs against a behavioural model of the console: the model turns each
// accepted byte into the list of cycles that must follow it (character
// writes, newline cycle, line clears, screen clears) and tracks the cursor
// and top line with plain modular arithmetic.
// -----------------------------------------------------------------------------
module tb_text_console_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;
  localparam int TOTAL  = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] cur_col;
  logic [5:0] cur_lin;
  logic [5:0] top_lin;

  always #5 clk = ~clk;

  text_console_writer_if #(.ADDR_W(ADDR_W)) bus ();

  text_console_writer #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .cursor_col_o(cur_col),
    .cursor_lin_o(cur_lin),
    .top_lin_o   (top_lin)
  );

  // One expected non-idle cycle: either a RAM write or a busy cycle.
  typedef struct {
    bit we;
    int addr;
    int data;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t cmp_c;
  int   m_col, m_lin, m_top;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   we_count  = 0;
  int   last_addr = -1;
  int   last_data = -1;

  task automatic check(input bit ok, input string name, input string act, input string exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  task automatic expect_int(input string name, input int act, input int exp);
    check(act == exp, name, $sformatf("%0d", act), $sformatf("%0d", exp));
  endtask

  // ---------------- behavioural model ----------------
  function automatic int phys_addr(int col);
    return ((m_top + m_lin) % ROWS) * COLS + col;
  endfunction

  function automatic void push_cycle(bit we, int addr, int data);
    cyc_t c;
    c.we   = we;
    c.addr = addr;
    c.data = data;
    exp_q.push_back(c);
  endfunction

  function automatic void model_newline();
    push_cycle(1'b0, 0, 0);
    m_col = 0;
    if (m_lin < ROWS - 1) begin
      m_lin++;
    end else begin
      m_top = (m_top + 1) % ROWS;
      for (int i = 0; i < COLS; i++) push_cycle(1'b1, phys_addr(i), 'h20);
    end
  endfunction

  function automatic void model_cls();
    for (int i = 0; i < TOTAL; i++) push_cycle(1'b1, i, 'h20);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_col = 0;
    m_lin = 0;
    m_top = 0;
  endfunction

  function automatic void model_byte(int b);
    if (b >= 'h20 && b <= 'h7E) begin
      push_cycle(1'b1, phys_addr(m_col), b);
      if (m_col < COLS - 1) m_col++;
      else model_newline();
    end else if (b == 'h0D) begin
      m_col = 0;
    end else if (b == 'h0A) begin
      model_newline();
    end else if (b == 'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 'h0C) begin
      m_col = 0;
      m_lin = 0;
      m_top = 0;
      model_cls();
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      check(bus.ram_we_o == 1'b0 && bus.chr_ready_o == 1'b0 && bus.ram_addr_o == '0 &&
            bus.ram_data_o == '0 && cur_col == '0 && cur_lin == '0 && top_lin == '0,
            "reset_state",
            $sformatf("we=%0b rdy=%0b addr=%0d data=%0h col=%0d lin=%0d top=%0d",
                      bus.ram_we_o, bus.chr_ready_o, bus.ram_addr_o, bus.ram_data_o,
                      cur_col, cur_lin, top_lin),
            "all zero");
    end else begin
      if (bus.ram_we_o) begin
        we_count++;
        last_addr = int'(bus.ram_addr_o);
        last_data = int'(bus.ram_data_o);
        check(last_addr < TOTAL, "addr_range", $sformatf("%0d", last_addr),
              $sformatf("< %0d", TOTAL));
      end
      if (exp_q.size() > 0) begin
        cmp_c = exp_q.pop_front();
        check(bus.chr_ready_o == 1'b0 && bus.ram_we_o == cmp_c.we &&
              (!cmp_c.we || (int'(bus.ram_addr_o) == cmp_c.addr &&
                             int'(bus.ram_data_o) == cmp_c.data)),
              "busy_cycle",
              $sformatf("rdy=%0b we=%0b addr=%0d data=%0h", bus.chr_ready_o, bus.ram_we_o,
                        bus.ram_addr_o, bus.ram_data_o),
              $sformatf("rdy=0 we=%0b addr=%0d data=%0h", cmp_c.we, cmp_c.addr, cmp_c.data));
      end else begin
        check(bus.chr_ready_o == 1'b1 && bus.ram_we_o == 1'b0 && int'(cur_col) == m_col &&
              int'(cur_lin) == m_lin && int'(top_lin) == m_top,
              "idle_cycle",
              $sformatf("rdy=%0b we=%0b col=%0d lin=%0d top=%0d", bus.chr_ready_o,
                        bus.ram_we_o, cur_col, cur_lin, top_lin),
              $sformatf("rdy=1 we=0 col=%0d lin=%0d top=%0d", m_col, m_lin, m_top));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int b);
    int budget = 0;
    bus.chr_i       = 8'(b);
    bus.chr_valid_i = 1'b1;
    while (!bus.chr_ready_o && budget < 20000) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!bus.chr_ready_o) begin
      check(1'b0, "accept_timeout", "ready never rose", "ready=1");
    end else begin
      @(posedge clk); #1;  // byte accepted at this edge
      model_byte(b);
    end
    bus.chr_valid_i = 1'b0;
    bus.chr_i       = 8'($urandom);
  endtask

  task automatic wait_idle();
    int budget = 0;
    do begin
      @(posedge clk); #1;
      budget++;
    end while (!(bus.chr_ready_o && exp_q.size() == 0) && budget < 20000);
    check(bus.chr_ready_o && exp_q.size() == 0, "reach_idle",
          $sformatf("rdy=%0b pending=%0d", bus.chr_ready_o, exp_q.size()), "rdy=1 pending=0");
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
    model_cls();
  endtask

  function automatic int random_byte();
    int r = $urandom_range(0, 99);
    int b;
    if (r < 60) return $urandom_range('h20, 'h7E);
    if (r < 72) return 'h0A;
    if (r < 78) return 'h0D;
    if (r < 86) return 'h08;
    if (r < 87) return 'h0C;
    b = $urandom_range(0, 255);
    if ((b >= 'h20 && b <= 'h7E) || b == 'h0A || b == 'h0D || b == 'h08 || b == 'h0C)
      b = 'h7F;
    return b;
  endfunction

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int snap;
    bus.chr_i       = 8'h00;
    bus.chr_valid_i = 1'b0;
    model_reset();

    // Reset release: full clear screen.
    repeat (3) @(posedge clk);
    release_reset();
    snap = we_count;
    wait_idle();
    expect_int("cls_write_count", we_count - snap, 4800);
    expect_int("cls_last_addr", last_addr, 4799);
    expect_int("cls_cursor_col", int'(cur_col), 0);
    expect_int("cls_cursor_lin", int'(cur_lin), 0);

    // 'A', 'B' at the home position.
    send('h41);
    send('h42);
    wait_idle();
    expect_int("ab_last_addr", last_addr, 1);
    expect_int("ab_last_data", last_data, 'h42);
    expect_int("ab_cursor_col", int'(cur_col), 2);

    // Auto-wrap at the last column.
    send('h0D);
    snap = we_count;
    repeat (78) send('h20);
    send('h58);
    send('h59);
    wait_idle();
    expect_int("wrap_last_addr", last_addr, 79);
    expect_int("wrap_last_data", last_data, 'h59);
    expect_int("wrap_write_count", we_count - snap, 80);
    expect_int("wrap_cursor_col", int'(cur_col), 0);
    expect_int("wrap_cursor_lin", int'(cur_lin), 1);
    send('h5A);
    wait_idle();
    expect_int("z_addr", last_addr, 80);

    // CR, BS at col 0, BS at col 5, unsupported byte.
    snap = we_count;
    send('h0D);
    wait_idle();
    expect_int("cr_col", int'(cur_col), 0);
    send('h08);
    wait_idle();
    expect_int("bs0_col", int'(cur_col), 0);
    expect_int("cr_bs_no_write", we_count - snap, 0);
    repeat (5) send('h61);
    wait_idle();
    snap = we_count;
    send('h08);
    wait_idle();
    expect_int("bs5_col", int'(cur_col), 4);
    send('h95);
    wait_idle();
    expect_int("other_col", int'(cur_col), 4);
    expect_int("bs_other_no_write", we_count - snap, 0);

    // Scroll: from line 1, 58 LFs reach the bottom, the 59th scrolls.
    snap = we_count;
    repeat (59) send('h0A);
    wait_idle();
    expect_int("scroll_top", int'(top_lin), 1);
    expect_int("scroll_lin", int'(cur_lin), 59);
    expect_int("scroll_clear_count", we_count - snap, 80);
    expect_int("scroll_clear_last", last_addr, 79);
    send('h51);
    wait_idle();
    expect_int("q_addr", last_addr, 0);
    expect_int("q_data", last_data, 'h51);

    // Randomised byte stream with random gaps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
        @(posedge clk); #1;
      end
      send(random_byte());
    end
    wait_idle();

    // FF after scrolling.
    repeat (60) send('h0A);
    wait_idle();
    snap = we_count;
    send('h0C);
    wait_idle();
    expect_int("ff_top", int'(top_lin), 0);
    expect_int("ff_col", int'(cur_col), 0);
    expect_int("ff_lin", int'(cur_lin), 0);
    expect_int("ff_write_count", we_count - snap, 4800);
    expect_int("ff_last_addr", last_addr, 4799);

    // Reset in the middle of a line clear.
    repeat (60) send('h0A);
    repeat (3) begin
      @(posedge clk); #1;
    end
    expect_int("in_clear_we", int'(bus.ram_we_o), 1);
    rst = 1'b1;
    model_reset();
    #1;
    expect_int("rst_we_now", int'(bus.ram_we_o), 0);
    expect_int("rst_top_now", int'(top_lin), 0);
    expect_int("rst_lin_now", int'(cur_lin), 0);
    repeat (2) @(posedge clk);
    release_reset();
    snap = we_count;
    wait_idle();
    expect_int("rerun_cls_count", we_count - snap, 4800);
    send('h41);
    wait_idle();
    expect_int("post_rst_addr", last_addr, 0);
    expect_int("post_rst_col", int'(cur_col), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
